// File: rtl/stream_byte_packer.sv
// Packs a sparse AXI4S byte stream (0..BYTES low-aligned bytes per beat) into dense full-width beats.
// Optional sticky keep-protocol checker: define STREAM_BYTE_PACKER_ERR_CHECK_EN.
module stream_byte_packer #(
  parameter int WIDTH       = 512,
  parameter int BYTES       = WIDTH / 8,
  parameter int COUNT_WIDTH = $clog2(BYTES) + 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic [BYTES-1:0] i_tkeep,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic [BYTES-1:0] o_tkeep,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_err,
  output logic             dbg_state
);

  // Handshake: a beat transfers on a rising aclk edge where valid && ready;
  // o_tvalid never depends on o_tready, and held data is stable while stalled.

  localparam int TW = COUNT_WIDTH + 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       carry;
  logic [COUNT_WIDTH-1:0] fill;

  logic [COUNT_WIDTH-1:0] n;
  logic [WIDTH-1:0]       in_masked;
  logic [2*WIDTH-1:0]     merge;
  logic [TW-1:0]          total;
  logic [COUNT_WIDTH-1:0] fill_rem;
  logic                   out_free;
  logic                   accept;

  function automatic logic [BYTES-1:0] low_mask(input logic [TW-1:0] cnt);
    logic [BYTES-1:0] m;
    m = '0;
    for (int k = 0; k < BYTES; k++) m[k] = (k < int'(cnt));
    return m;
  endfunction

  // Bytes above the highest keep bit are dropped so the carry stays zero above fill.
  always_comb begin
    n         = '0;
    in_masked = '0;
    for (int k = 0; k < BYTES; k++)
      if (i_tkeep[k]) n = COUNT_WIDTH'(k + 1);
    for (int k = 0; k < BYTES; k++)
      if (k < int'(n)) in_masked[8*k +: 8] = i_tdata[8*k +: 8];
  end

  assign merge    = {{WIDTH{1'b0}}, carry} | ({{WIDTH{1'b0}}, in_masked} << {fill, 3'b000});
  assign total    = TW'(fill) + TW'(n);
  assign fill_rem = COUNT_WIDTH'(total - TW'(BYTES));
  assign out_free = !o_tvalid || o_tready;
  assign i_tready = (state == RUN) && out_free && !areset;
  assign accept   = i_tvalid && i_tready;
  assign dbg_state = (state == FLUSH);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= RUN;
      carry    <= '0;
      fill     <= '0;
      o_tdata  <= '0;
      o_tkeep  <= '0;
      o_tlast  <= 1'b0;
      o_tvalid <= 1'b0;
    end else begin
      if (o_tvalid && o_tready) o_tvalid <= 1'b0;
      if (state == FLUSH) begin
        if (out_free) begin
          o_tdata  <= carry;
          o_tkeep  <= low_mask(TW'(fill));
          o_tlast  <= 1'b1;
          o_tvalid <= 1'b1;
          carry    <= '0;
          fill     <= '0;
          state    <= RUN;
        end
      end else if (accept) begin
        if (i_tlast && total <= TW'(BYTES)) begin
          o_tdata  <= merge[WIDTH-1:0];
          o_tkeep  <= low_mask(total);
          o_tlast  <= 1'b1;
          o_tvalid <= 1'b1;
          carry    <= '0;
          fill     <= '0;
        end else if (total >= TW'(BYTES)) begin
          // A tlast beat that overflows leaves a remainder for the FLUSH cycle.
          o_tdata  <= merge[WIDTH-1:0];
          o_tkeep  <= '1;
          o_tlast  <= 1'b0;
          o_tvalid <= 1'b1;
          carry    <= merge[2*WIDTH-1:WIDTH];
          fill     <= fill_rem;
          if (i_tlast) state <= FLUSH;
        end else begin
          carry <= merge[WIDTH-1:0];
          fill  <= total[COUNT_WIDTH-1:0];
        end
      end
    end
  end

`ifdef STREAM_BYTE_PACKER_ERR_CHECK_EN
  logic [BYTES-1:0] keep_inc;
  assign keep_inc = i_tkeep + BYTES'(1);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      o_err <= 1'b0;
    end else if (accept) begin
      if (((i_tkeep & keep_inc) != '0) || ((i_tkeep == '0) && !i_tlast)) o_err <= 1'b1;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule
